// File: rtl/mips_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the data word width, the responder FSM state type, the default
// depth and wait-state settings, and a small address-alignment helper.
package mips_pkg;

  localparam int WORD_W              = 32;
  localparam int DEFAULT_DEPTH_WORDS = 256;
  localparam int DEFAULT_WAIT_CYCLES = 2;
  // Wait counter width; WAIT_CYCLES is limited to 0..15.
  localparam int CNT_W               = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // A word access is misaligned when either byte-offset bit is set.
  function automatic logic is_misaligned(input logic [WORD_W-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data storage for data_mem_responder.
// Synchronous write, combinational read from the same word index.
// Contents have no reset so benches can preload "memory" hierarchically.
// Ports:
//   clk      - clock, writes on rising edge
//   we_i     - write enable for idx_i
//   idx_i    - word index (read and write)
//   wdata_i  - write data
//   rdata_o  - combinational read data of memory[idx_i]
module dmem_array
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     idx_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] memory [DEPTH_WORDS];

  // Word write; storage is intentionally left out of any reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      memory[idx_i] <= wdata_i;
    end
  end

  assign rdata_o = memory[idx_i];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store request at a time over a
// valid/ready request channel, waits WAIT_CYCLES cycles, then presents a
// registered response held until the core takes it.
// Optional feature macro: DMEM_ALIGN_CHECK_EN -- when defined, misaligned
// requests are timed normally but never write and respond with rsp_err=1.
// Ports:
//   clk, reset            - clock and synchronous active-high reset
//   req_valid/req_ready   - request handshake (ready only in IDLE)
//   req_we                - 1 store, 0 load
//   req_addr, req_wdata   - byte address and store data
//   rsp_valid/rsp_ready   - response handshake
//   rsp_rdata, rsp_err    - load data (0 for stores) and misalignment flag
module data_mem_responder
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int               AW        = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [WORD_W-1:0] WORD_ZERO = {WORD_W{1'b0}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, err_q;
  logic [AW-1:0]     idx_q;
  logic [WORD_W-1:0] wdata_q;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [WORD_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic              req_ready_s, accept_s, enter_resp_s, req_err_s;
  logic              cur_we_s, cur_err_s, mem_we_s;
  logic [AW-1:0]     cur_idx_s;
  logic [WORD_W-1:0] cur_wdata_s, mem_rdata_s;
  logic              unused_addr_s;

`ifdef DMEM_ALIGN_CHECK_EN
  assign req_err_s = is_misaligned(req_addr);
`else
  assign req_err_s = 1'b0;
`endif
  // Bits above the word index wrap away; byte offset only matters for the check.
  assign unused_addr_s = ^{req_addr[WORD_W-1:AW+2], req_addr[1:0]};

  assign accept_s = req_valid && req_ready_s;

  // State register and wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          cnt_d   = CNT_LOAD;
          state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Output decode of the state.
  always_comb begin
    req_ready_s = 1'b0;
    case (state_q)
      IDLE:    req_ready_s = 1'b1;
      WAIT:    req_ready_s = 1'b0;
      RESP:    req_ready_s = 1'b0;
      default: req_ready_s = 1'b0;
    endcase
  end

  // Latched request fields, captured on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= {AW{1'b0}};
      wdata_q <= WORD_ZERO;
    end else if (accept_s) begin
      we_q    <= req_we;
      err_q   <= req_err_s;
      idx_q   <= req_addr[AW+1:2];
      wdata_q <= req_wdata;
    end else begin
      we_q    <= we_q;
      err_q   <= err_q;
      idx_q   <= idx_q;
      wdata_q <= wdata_q;
    end
  end

  // With zero wait states RESP is entered on the accept edge itself, so the
  // live request must be used there instead of the (not yet) latched copy.
  always_comb begin
    cur_we_s    = we_q;
    cur_err_s   = err_q;
    cur_idx_s   = idx_q;
    cur_wdata_s = wdata_q;
    if (state_q == IDLE) begin
      cur_we_s    = req_we;
      cur_err_s   = req_err_s;
      cur_idx_s   = req_addr[AW+1:2];
      cur_wdata_s = req_wdata;
    end else begin
      cur_we_s    = we_q;
    end
  end

  assign enter_resp_s = (state_d == RESP) && (state_q != RESP);
  // Reset gates the write so an abandoned store never reaches storage.
  assign mem_we_s = enter_resp_s && cur_we_s && !cur_err_s && !reset;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_mem (
    .clk    (clk),
    .we_i   (mem_we_s),
    .idx_i  (cur_idx_s),
    .wdata_i(cur_wdata_s),
    .rdata_o(mem_rdata_s)
  );

  // Response next-state: load on RESP entry, clear valid on handshake.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    if (enter_resp_s) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = cur_err_s;
      if (cur_we_s || cur_err_s) begin
        rsp_rdata_d = WORD_ZERO;
      end else begin
        rsp_rdata_d = mem_rdata_s;
      end
    end else if ((state_q == RESP) && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // Response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= WORD_ZERO;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = req_ready_s;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (WAIT_CYCLES=2 and 0) share
// one stimulus stream; a transaction-level model per instance predicts
// ready/valid/data every cycle, plus directed literal checks.
module tb_data_mem_responder;

  localparam int DEPTH = 256;
  localparam int W0    = 2;
  localparam int W1    = 0;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic        rsp_ready = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [1:0]  req_ready_o, rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_rdata_o [2];

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  int edge_n = 0;

  // Transaction-level model state per instance.
  bit          m_busy [2];
  bit          m_resp [2];
  int          m_acc  [2];
  logic        m_we   [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_data [2];
  logic [31:0] m_rdata[2];
  logic        m_err  [2];
  logic [31:0] mem_m  [2][DEPTH];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W0)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_o[0]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_o[0]), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata_o[0]), .rsp_err(rsp_err_o[0]));

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W1)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_o[1]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_o[1]), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata_o[1]), .rsp_err(rsp_err_o[1]));

  function automatic int wt(input int k);
    return (k == 0) ? W0 : W1;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic logic merr(input logic [31:0] a);
    return ALIGN && (a % 4 != 0);
  endfunction

  function automatic logic [31:0] exp_rd(input int k, input logic we, input logic [31:0] a);
    return (merr(a) || we) ? 32'h0 : mem_m[k][widx(a)];
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference model: a request is answered WAIT edges after its accept edge.
  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_busy[k] <= 1'b0;
        m_resp[k] <= 1'b0;
      end else if (!m_busy[k]) begin
        if (req_valid) begin
          m_busy[k] <= 1'b1;
          m_acc[k]  <= edge_n;
          m_we[k]   <= req_we;
          m_addr[k] <= req_addr;
          m_data[k] <= req_wdata;
          if (wt(k) == 0) begin
            m_resp[k]  <= 1'b1;
            m_err[k]   <= merr(req_addr);
            m_rdata[k] <= exp_rd(k, req_we, req_addr);
            if (req_we && !merr(req_addr)) mem_m[k][widx(req_addr)] <= req_wdata;
          end
        end
      end else if (m_resp[k]) begin
        if (rsp_ready) begin
          m_busy[k] <= 1'b0;
          m_resp[k] <= 1'b0;
        end
      end else if (edge_n == m_acc[k] + wt(k)) begin
        m_resp[k]  <= 1'b1;
        m_err[k]   <= merr(m_addr[k]);
        m_rdata[k] <= exp_rd(k, m_we[k], m_addr[k]);
        if (m_we[k] && !merr(m_addr[k])) mem_m[k][widx(m_addr[k])] <= m_data[k];
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("req_ready[%0d]", k), {31'b0, req_ready_o[k]}, {31'b0, !m_busy[k]});
        chk($sformatf("rsp_valid[%0d]", k), {31'b0, rsp_valid_o[k]}, {31'b0, m_resp[k]});
        if (m_resp[k]) begin
          chk($sformatf("rsp_rdata[%0d]", k), rsp_rdata_o[k], m_rdata[k]);
          chk($sformatf("rsp_err[%0d]", k), {31'b0, rsp_err_o[k]}, {31'b0, m_err[k]});
        end
      end
    end
  end

  // One request/response; hold>0 keeps rsp_ready low and pokes req_valid.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] data,
                      input int hold, output logic [31:0] rd, output logic er,
                      output int lat, output logic v1);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready_o[0] && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_wait_bound", {31'b0, guard < 40}, 32'h1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    v1  = rsp_valid_o[1];
    lat = 1;
    while (!rsp_valid_o[0] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("rsp_wait_bound", {31'b0, lat < 40}, 32'h1);
    rd = rsp_rdata_o[0];
    er = rsp_err_o[0];
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      @(negedge clk);
      chk("bp_valid", {31'b0, rsp_valid_o[0]}, 32'h1);
      chk("bp_ready", {31'b0, req_ready_o[0]}, 32'h0);
      chk("bp_rdata", rsp_rdata_o[0], 32'hDEADBEEF);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (hold > 0) begin
      chk("no_accept_on_handshake", {31'b0, req_ready_o[0]}, 32'h1);
      req_valid = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, v;
    logic        er, v1;
    int          lat;
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      if (i == 1) v = 32'hDEADBEEF;
      if (i == 3) v = 32'h12345678;
      dut.u_mem.memory[i]  <= v;
      dut0.u_mem.memory[i] <= v;
      mem_m[0][i] <= v;
      mem_m[1][i] <= v;
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;
    chk("reset_valid", {30'b0, rsp_valid_o}, 32'h0);
    chk("reset_ready", {30'b0, req_ready_o}, 32'h3);
    chk("reset_rdata", rsp_rdata_o[0], 32'h0);
    chk("reset_err", {30'b0, rsp_err_o}, 32'h0);

    // Plain load of a preloaded word, latency WAIT+1 and zero-wait instance.
    xact(1'b0, 32'h4, 32'h0, 0, rd, er, lat, v1);
    chk("load_rdata", rd, 32'hDEADBEEF);
    chk("load_err", {31'b0, er}, 32'h0);
    chk("load_latency", lat, 32'd3);
    chk("zero_wait_valid", {31'b0, v1}, 32'h1);

    // Store then load.
    xact(1'b1, 32'h8, 32'h5, 0, rd, er, lat, v1);
    chk("store_rdata", rd, 32'h0);
    chk("store_mem2", dut.u_mem.memory[2], 32'h5);
    xact(1'b0, 32'h8, 32'h0, 0, rd, er, lat, v1);
    chk("reload_rdata", rd, 32'h5);

    // Backpressure with an ignored request.
    xact(1'b0, 32'h4, 32'h0, 4, rd, er, lat, v1);
    chk("bp_first_rdata", rd, 32'hDEADBEEF);

    // Reset during the first wait cycle of a store.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'hC; req_wdata = 32'hAAAAAAAA;
    @(negedge clk);
    req_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_store_mem3", dut.u_mem.memory[3], 32'h12345678);
    chk("rst_store_valid", {31'b0, rsp_valid_o[0]}, 32'h0);
    chk("rst_store_ready", {31'b0, req_ready_o[0]}, 32'h1);

    // Address wrap.
    xact(1'b0, 32'h404, 32'h0, 0, rd, er, lat, v1);
    chk("wrap_rdata", rd, 32'hDEADBEEF);

    // Misaligned store.
    xact(1'b1, 32'h6, 32'h0BADF00D, 0, rd, er, lat, v1);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("align_err", {31'b0, er}, 32'h1);
    chk("align_mem1", dut.u_mem.memory[1], 32'hDEADBEEF);
`else
    chk("align_err", {31'b0, er}, 32'h0);
    chk("align_mem1", dut.u_mem.memory[1], 32'h0BADF00D);
`endif

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      req_valid = ($urandom_range(0, 2) != 0);
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = $urandom & 32'h0000_07FF;
      if ($urandom_range(0, 3) != 0) req_addr[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) req_addr[31:12] = 20'($urandom);
      req_wdata = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 99) == 0);
    end
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (10) @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("mem0[%0d]", i), dut.u_mem.memory[i], mem_m[0][i]);
      chk($sformatf("mem1[%0d]", i), dut0.u_mem.memory[i], mem_m[1][i]);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, SHALL set the number of 32-bit words stored (power of two).
REQ-002 Parameter WAIT_CYCLES, default 2, SHALL set the wait states inserted between request accept and response (0..15).
REQ-003 Ports SHALL be, in order:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store (SW), 0 = load (LW).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  core accepts the response.
- rsp_rdata  out  32  load data; 0 for stores.
- rsp_err  out  1  misaligned-access flag.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-005 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on an edge where req_valid and req_ready are both 1.
REQ-006 On accept, the block SHALL latch req_we, req_addr and req_wdata, load the wait counter with WAIT_CYCLES, and go to WAIT, or directly to RESP when WAIT_CYCLES = 0.
REQ-007 In WAIT, the counter SHALL decrement by 1 each cycle; the FSM SHALL move to RESP on the edge where the counter equals 1.
REQ-008 rsp_valid SHALL first be 1 exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-009 Stores SHALL commit to storage on the edge that enters RESP.
REQ-010 Load data SHALL be registered into rsp_rdata on that same edge.
REQ-011 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_ready = 1; on that edge the FSM SHALL return to IDLE and rsp_valid SHALL clear.
REQ-012 A new request SHALL NOT be accepted on the same edge as a response handshake; the minimum request spacing is WAIT_CYCLES+2 cycles.
REQ-013 The word index SHALL be req_addr[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo DEPTH_WORDS*4.
REQ-014 req_valid asserted outside IDLE SHALL have no effect.

Reset
REQ-015 Reset SHALL force state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0 and latched request fields=0; req_ready SHALL read 1 in the cycle after reset.
REQ-016 Reset during WAIT SHALL abandon the pending request; an uncommitted store SHALL NOT modify storage.
REQ-017 Storage contents SHALL NOT be cleared by reset; they are preloadable hierarchically by benches.

Configuration
REQ-018 With macro DMEM_ALIGN_CHECK_EN defined, a request with req_addr[1:0] != 0 SHALL still be accepted and timed normally, SHALL NOT write storage, and SHALL respond with rsp_err=1 and rsp_rdata=0.
REQ-019 Without DMEM_ALIGN_CHECK_EN, req_addr[1:0] SHALL be ignored and rsp_err SHALL be tied to 0.

Structure
REQ-020 Shared package mips_pkg SHALL hold WORD_W=32, the FSM state typedef and the default DEPTH_WORDS/WAIT_CYCLES constants.
REQ-021 Storage SHALL be a sub-module, dmem_array, with synchronous write, combinational read, and an array named memory indexed by word.
REQ-022 The FSM, counter and response registers SHALL live in data_mem_responder.

Verification
REQ-023 Load: WAIT_CYCLES=2, memory[1]=DEADBEEF; load at addr 4 -> rsp_valid 3 cycles after accept, rsp_rdata=DEADBEEF, rsp_err=0.
REQ-024 Store then load: store 00000005 to addr 8, then load addr 8 -> memory[2]=00000005, store rsp_rdata=0, load rsp_rdata=00000005.
REQ-025 Backpressure: hold rsp_ready=0 for 4 cycles in RESP -> rsp_valid=1 and rsp_rdata unchanged throughout, req_ready=0, and a second req_valid is ignored.
REQ-026 Reset mid-store: store AAAAAAAA to addr 12, reset in the first WAIT cycle -> memory[3] unchanged, rsp_valid=0, req_ready=1 in the cycle after reset.
REQ-027 Wrap and zero-wait: DEPTH_WORDS=256, load at addr 0x404 -> returns memory[1]; with WAIT_CYCLES=0, rsp_valid 1 cycle after accept.
REQ-028 Alignment: with DMEM_ALIGN_CHECK_EN, store to addr 6 -> rsp_err=1, memory[1] unchanged; without it, the same store writes memory[1].
